// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the FSM state encoding and the counter-width helper.
package ccff_pkg;

  localparam int WORD_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    RB_SHIFT,
    RB_OUT,
    DONE
  } state_t;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// Word-wide shift register shared by the programming (shift out, LSB first)
// and readback (shift in from the MSB side) directions, with a bit index.
module ccff_word_serdes
  import ccff_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift_out,
  input  logic              shift_in,
  input  logic              serial_in,
  output logic              lsb,
  output logic              last_bit,
  output logic [WORD_W-1:0] justified
);

  localparam int IW = cnt_width(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] shifted_in;

  assign shifted_in = (shreg >> 1) | (WORD_W'(serial_in) << (WORD_W - 1));
  assign lsb        = shreg[0];
  assign last_bit   = (idx == IW'(WORD_W - 1));

  // Value of the word after the current shift-in, moved down so that the
  // first bit captured lands in bit 0 even when the word is only partial.
  assign justified  = shifted_in >> (IW'(WORD_W) - (idx + IW'(1)));

  always_ff @(posedge prog_clk) begin
    if (reset || clear) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_data;
      idx   <= '0;
    end else if (shift_out || shift_in) begin
      shreg <= shift_out ? (shreg >> 1) : shifted_in;
      idx   <= last_bit ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream bytes onto ccff_head and
// supports non-destructive readback by recirculating ccff_tail to ccff_head.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = WORD_W_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start_prog,
  input  logic              start_rb,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(CHAIN_LEN);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              chain_full_next;
  logic              word_last;
  logic              word_lsb;
  logic [WORD_W-1:0] rb_word;

  assign cnt_next        = cnt + CW'(1);
  assign chain_full_next = (cnt_next == CW'(CHAIN_LEN));

  ccff_word_serdes #(
    .WORD_W(WORD_W)
  ) u_serdes (
    .prog_clk  (prog_clk),
    .reset     (pReset),
    .clear     (state == IDLE),
    .load      ((state == FETCH) && bs_valid && bs_ready),
    .load_data (bs_data),
    .shift_out (state == SHIFT),
    .shift_in  (state == RB_SHIFT),
    .serial_in (ccff_tail),
    .lsb       (word_lsb),
    .last_bit  (word_last),
    .justified (rb_word)
  );

  // During readback the tail is fed straight back to the head so the chain
  // rotates and ends up unchanged after CHAIN_LEN shifts.
  always_comb begin
    ccff_head = 1'b0;
    case (state)
      SHIFT:    ccff_head = word_lsb;
      RB_SHIFT: ccff_head = ccff_tail;
      default:  ccff_head = 1'b0;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state       <= IDLE;
      cnt         <= '0;
      bs_ready    <= 1'b0;
      rb_valid    <= 1'b0;
      rb_data     <= '0;
      prog_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_prog) begin
            state    <= FETCH;
            cnt      <= '0;
            busy     <= 1'b1;
            bs_ready <= 1'b1;
          end else if (start_rb) begin
            state       <= RB_SHIFT;
            cnt         <= '0;
            busy        <= 1'b1;
            prog_clk_en <= 1'b1;
          end
        end
        FETCH: begin
          if (bs_valid && bs_ready) begin
            state       <= SHIFT;
            bs_ready    <= 1'b0;
            prog_clk_en <= 1'b1;
          end
        end
        // Chain end takes priority over word end: surplus bits are dropped.
        SHIFT: begin
          cnt <= cnt_next;
          if (chain_full_next) begin
            state       <= DONE;
            prog_clk_en <= 1'b0;
            done        <= 1'b1;
          end else if (word_last) begin
            state       <= FETCH;
            prog_clk_en <= 1'b0;
            bs_ready    <= 1'b1;
          end
        end
        RB_SHIFT: begin
          cnt <= cnt_next;
          if (chain_full_next || word_last) begin
            state       <= RB_OUT;
            prog_clk_en <= 1'b0;
            rb_valid    <= 1'b1;
            rb_data     <= rb_word;
          end
        end
        RB_OUT: begin
          if (rb_valid && rb_ready) begin
            rb_valid <= 1'b0;
            if (cnt == CW'(CHAIN_LEN)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RB_SHIFT;
              prog_clk_en <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bs_ready    <= 1'b0;
          rb_valid    <= 1'b0;
          prog_clk_en <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
